// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet II/IPv4/UDP frame constants, frame builder state enum and the ones_add16 ones-complement add
package eth_pkg;
  localparam int FRAME_LEN = 200;
  localparam int HDR_LEN = 42;
  localparam int PAYLOAD_MAX = FRAME_LEN - HDR_LEN;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam logic [15:0] IP_TOTAL_LEN = 16'(FRAME_LEN - 14);
  localparam logic [15:0] UDP_LEN = 16'(PAYLOAD_MAX + 8);
  typedef enum logic [2:0] {IDLE, CSUM, HDR, PAY, DROP, PAD, START, WAITTX} state_t;
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction
endpackage

// File: rtl/ipv4_csum.sv
// ipv4_csum: ones-complement accumulator (clk, rst_n; clr zeroes, add folds word in; sum = running total)
module ipv4_csum
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] word,
  output logic [15:0] sum
);
  logic [15:0] sum_q, sum_d;
  always_comb sum_d = clr ? 16'h0000 : add ? ones_add16(sum_q, word) : sum_q;
  always_ff @(posedge clk) begin
    if (!rst_n) sum_q <= 16'h0000;
    else sum_q <= sum_d;
  end
  assign sum = sum_q;
endmodule

// File: rtl/udp_frame_builder.sv
// udp_frame_builder: builds a 200-byte Eth/IPv4/UDP frame (payload via s_data/s_valid/s_last/s_ready) into the tx buffer via w_addr/w_data/w_en, then holds start until tx_busy; pulses frame_done/overflow
module udp_frame_builder
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC  = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC  = 48'h020000000001,
  parameter logic [31:0] SRC_IP   = 32'hC0A8010A,
  parameter logic [31:0] DST_IP   = 32'hC0A80101,
  parameter logic [15:0] SRC_PORT = 16'd1234,
  parameter logic [15:0] DST_PORT = 16'd1234,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] w_addr,
  output logic [7:0] w_data,
  output logic       w_en,
  output logic       start,
  input  logic       tx_busy,
  output logic       frame_done,
  output logic       overflow
);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, w_addr_q, w_addr_d, w_data_q, w_data_d;
  logic [15:0] id_q, id_d, sum;
  logic w_en_q, w_en_d, overflow_q, overflow_d, frame_done_q, frame_done_d, take;
  logic [9:0][15:0] words;
  logic [HDR_LEN-1:0][7:0] hdr;
  assign words = {16'h4500, IP_TOTAL_LEN, id_q, 16'h4000, TTL, IP_PROTO_UDP, 16'h0000, SRC_IP, DST_IP};
  assign hdr = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, 16'h4500, IP_TOTAL_LEN, id_q, 16'h4000, TTL, IP_PROTO_UDP,
                ~sum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};
  ipv4_csum u_csum (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE),
    .add  (state_q == CSUM),
    .word (words[4'(9) - cnt_q[3:0]]),
    .sum  (sum)
  );
  assign s_ready = (state_q == PAY) || (state_q == DROP);
  assign start = state_q == START;
  assign take = s_valid && s_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    id_d = id_q;
    w_en_d = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    overflow_d = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        state_d = (s_valid && !tx_busy) ? CSUM : IDLE;
      end
      CSUM: begin
        cnt_d = (cnt_q == 8'd9) ? 8'd0 : cnt_q + 8'd1;
        state_d = (cnt_q == 8'd9) ? HDR : CSUM;
      end
      HDR: begin
        w_en_d = 1'b1;
        w_addr_d = cnt_q;
        w_data_d = hdr[6'(HDR_LEN - 1) - cnt_q[5:0]];
        cnt_d = (cnt_q == 8'(HDR_LEN - 1)) ? 8'd0 : cnt_q + 8'd1;
        state_d = (cnt_q == 8'(HDR_LEN - 1)) ? PAY : HDR;
      end
      PAY: if (take) begin
        w_en_d = 1'b1;
        w_addr_d = 8'(HDR_LEN) + cnt_q;
        w_data_d = s_data;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(PAYLOAD_MAX - 1)) begin
          state_d = s_last ? START : DROP;
          overflow_d = !s_last;
        end else if (s_last) state_d = PAD;
      end
      DROP: state_d = (take && s_last) ? START : DROP;
      PAD: begin
        w_en_d = 1'b1;
        w_addr_d = 8'(HDR_LEN) + cnt_q;
        w_data_d = 8'h00;
        cnt_d = cnt_q + 8'd1;
        state_d = (cnt_q == 8'(PAYLOAD_MAX - 1)) ? START : PAD;
      end
      START: state_d = tx_busy ? WAITTX : START;
      WAITTX: if (!tx_busy) begin
        frame_done_d = 1'b1;
        id_d = id_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      id_q <= 16'd0;
      w_en_q <= 1'b0;
      w_addr_q <= 8'd0;
      w_data_q <= 8'd0;
      overflow_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      id_q <= id_d;
      w_en_q <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      overflow_q <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign w_en = w_en_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;
  assign overflow = overflow_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_udp_frame_builder.sv
// tb_udp_frame_builder: directed self-checking bench for udp_frame_builder with a captured frame buffer and a scripted transmitter
module tb_udp_frame_builder;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, tx_busy = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, w_en, start, frame_done, overflow;
  logic [7:0] w_addr, w_data;
  logic [7:0] mem [256];
  logic start_p = 1'b0;
  int n_cmp = 0, n_err = 0;
  int n_wr = 0, n_bwr = 0, n_brdy = 0, n_ovf = 0, n_done = 0, n_start = 0;
  int b_wr, b_bwr, b_ovf, b_done, b_start;

  udp_frame_builder dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .w_addr(w_addr), .w_data(w_data), .w_en(w_en), .start(start), .tx_busy(tx_busy),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
      n_wr <= n_wr + 1;
      if (tx_busy) n_bwr <= n_bwr + 1;
    end
    if (s_ready && tx_busy) n_brdy <= n_brdy + 1;
    if (overflow) n_ovf <= n_ovf + 1;
    if (frame_done) n_done <= n_done + 1;
    if (start && !start_p) n_start <= n_start + 1;
    start_p <= start;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_w_en"}, w_en, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_w_data"}, w_data, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic snap();
    b_wr = n_wr; b_bwr = n_bwr; b_ovf = n_ovf; b_done = n_done; b_start = n_start;
  endtask

  task automatic send(input int n, input logic [7:0] seed);
    int got = 0;
    int t = 0;
    for (int i = 0; i < n && t < 2000; i++) begin
      s_valid = 1'b1;
      s_data = 8'(i) + seed;
      s_last = (i == n - 1);
      while (!s_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (s_ready) begin
        @(negedge clk);
        got++;
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    check("bytes_accepted", got, n);
  endtask

  task automatic run_tx(input int hold);
    int t = 0;
    int low = 0;
    while (!start && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("start_seen", start, 1);
    repeat (hold) begin
      @(negedge clk);
      if (!start) low++;
    end
    check("start_held", low, 0);
    tx_busy = 1'b1;
    @(negedge clk);
    check("start_drop", start, 0);
    repeat (5) @(negedge clk);
    tx_busy = 1'b0;
    t = 0;
    while (!frame_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("frame_done", frame_done, 1);
  endtask

  task automatic check_frame(input int n, input logic [7:0] seed, input logic [15:0] id, input logic [15:0] csum, input int ovf);
    logic [335:0] eh;
    logic [7:0] e;
    eh = {48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 16'h4500, 16'h00BA, id, 16'h4000, 8'h40, 8'h11,
          csum, 32'hC0A8010A, 32'hC0A80101, 16'h04D2, 16'h04D2, 16'h00A6, 16'h0000};
    repeat (2) @(negedge clk);
    check("writes", n_wr - b_wr, 200);
    check("busy_writes", n_bwr - b_bwr, 0);
    check("start_pulses", n_start - b_start, 1);
    check("done_pulses", n_done - b_done, 1);
    check("overflow_pulses", n_ovf - b_ovf, ovf);
    for (int i = 0; i < 42; i++) check($sformatf("hdr%0d", i), mem[i], eh[335 - 8 * i -: 8]);
    for (int i = 0; i < 158; i++) begin
      e = (i < n) ? 8'(i) + seed : 8'h00;
      check($sformatf("pay%0d", i), mem[42 + i], e);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    snap();
    send(158, 8'h00);
    run_tx(3);
    check_frame(158, 8'h00, 16'h0000, 16'hB6D7, 0);
    check("id_after_first", dut.id_q, 16'h0001);

    snap();
    send(10, 8'h30);
    run_tx(3);
    check_frame(10, 8'h30, 16'h0001, 16'hB6D6, 0);

    snap();
    send(170, 8'h80);
    run_tx(3);
    check_frame(158, 8'h80, 16'h0002, 16'hB6D5, 1);

    snap();
    tx_busy = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hC0;
    repeat (30) @(negedge clk);
    check("busy_no_write", n_wr - b_wr, 0);
    check("busy_no_ready", n_brdy, 0);
    tx_busy = 1'b0;
    send(10, 8'hC0);
    run_tx(50);
    check_frame(10, 8'hC0, 16'h0003, 16'hB6D4, 0);

    s_valid = 1'b1;
    s_data = 8'h11;
    for (int t = 0; t < 200 && !s_ready; t++) @(negedge clk);
    check("pay_reached", s_ready, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check_reset_outs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    snap();
    send(10, 8'h50);
    run_tx(3);
    check_frame(10, 8'h50, 16'h0000, 16'hB6D7, 0);

    force dut.id_q = 16'hFFFF;
    @(negedge clk);
    release dut.id_q;
    @(negedge clk);
    snap();
    send(10, 8'h70);
    run_tx(3);
    check_frame(10, 8'h70, 16'hFFFF, 16'hB6D7, 0);
    check("id_wrap", dut.id_q, 16'h0000);

    snap();
    send(4, 8'hA0);
    run_tx(3);
    check_frame(4, 8'hA0, 16'h0000, 16'hB6D7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
